// File: rtl/adc_controller.sv
// rtl/adc_controller.sv - I2S receive master for the stereo audio ADC
//
// Generates the ADC clocks (mclk_adc, sclk_adc, lrck_adc) from clk and
// deserializes sdata_adc MSB-first into left/right samples, one-bit I2S delay.
//
// Ports:
//   clk           in   system clock, all logic on rising edge
//   rst           in   asynchronous active-high reset
//   sdata_adc     in   serial data, changes after sclk_adc falling edges
//   mclk_adc      out  ADC master clock, clk/2
//   sclk_adc      out  bit clock, clk/(2*SCLK_HALF)
//   lrck_adc      out  word select, 0 = left, 1 = right
//   data_adc_chL  out  last complete left sample
//   data_adc_chR  out  last complete right sample
//   data_valid    out  one-cycle strobe when both channel outputs update
module adc_controller #(
  parameter int DATA_W      = 24,
  parameter int BITS_PER_CH = 32,
  parameter int SCLK_HALF   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdata_adc,
  output logic              mclk_adc,
  output logic              sclk_adc,
  output logic              lrck_adc,
  output logic [DATA_W-1:0] data_adc_chL,
  output logic [DATA_W-1:0] data_adc_chR,
  output logic              data_valid
);

  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int CNT_W = (BITS_PER_CH > 1) ? $clog2(BITS_PER_CH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(BITS_PER_CH - 1);
  localparam logic [CNT_W-1:0] SLOT_LSB = CNT_W'(DATA_W);

  logic              mclk_q, mclk_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sclk_q, sclk_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic              lrck_q, lrck_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] chl_q, chl_d;
  logic [DATA_W-1:0] chr_q, chr_d;
  logic              valid_q, valid_d;
  // Word-complete flag raised at the LSB capture edge; the word is moved
  // out on the following edge, tagged with the channel it belonged to
  // (lrck may toggle on that very edge when BITS_PER_CH = DATA_W+1).
  logic              done_q, done_d;
  logic              done_right_q, done_right_d;

  logic wrap, rise, fall;

  always_comb begin
    wrap = (div_q == DIV_LAST);
    rise = wrap && !sclk_q;
    fall = wrap && sclk_q;

    mclk_d       = ~mclk_q;
    div_d        = wrap ? '0 : div_q + DIV_W'(1);
    sclk_d       = wrap ? ~sclk_q : sclk_q;
    bit_d        = bit_q;
    lrck_d       = lrck_q;
    shift_d      = shift_q;
    left_d       = left_q;
    chl_d        = chl_q;
    chr_d        = chr_q;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    done_right_d = done_right_q;

    if (fall) begin
      if (bit_q == SLOT_LAST) begin
        bit_d  = '0;
        lrck_d = ~lrck_q;
      end else begin
        bit_d = bit_q + CNT_W'(1);
      end
    end

    // Slot 0 is the I2S delay bit; slots past the LSB are padding.
    if (rise && (bit_q != '0) && (bit_q <= SLOT_LSB)) begin
      shift_d = {shift_q[DATA_W-2:0], sdata_adc};
    end

    if (rise && (bit_q == SLOT_LSB)) begin
      done_d       = 1'b1;
      done_right_d = lrck_q;
    end

    if (done_q) begin
      if (done_right_q) begin
        chr_d   = shift_q;
        chl_d   = left_q;
        valid_d = 1'b1;
      end else begin
        left_d = shift_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mclk_q       <= 1'b0;
      div_q        <= '0;
      sclk_q       <= 1'b0;
      bit_q        <= '0;
      lrck_q       <= 1'b0;
      shift_q      <= '0;
      left_q       <= '0;
      chl_q        <= '0;
      chr_q        <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      done_right_q <= 1'b0;
    end else begin
      mclk_q       <= mclk_d;
      div_q        <= div_d;
      sclk_q       <= sclk_d;
      bit_q        <= bit_d;
      lrck_q       <= lrck_d;
      shift_q      <= shift_d;
      left_q       <= left_d;
      chl_q        <= chl_d;
      chr_q        <= chr_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      done_right_q <= done_right_d;
    end
  end

  assign mclk_adc     = mclk_q;
  assign sclk_adc     = sclk_q;
  assign lrck_adc     = lrck_q;
  assign data_adc_chL = chl_q;
  assign data_adc_chR = chr_q;
  assign data_valid   = valid_q;

endmodule

// File: tb/tb_adc_controller.sv
// tb/tb_adc_controller.sv - self-checking bench for adc_controller
module tb_adc_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default parameters. Instance 1: SCLK_HALF=1, BITS_PER_CH=25.
  logic        rst0, rst1;
  logic        sd0, sd1;
  logic        mclk0, sclk0, lrck0, dv0;
  logic        mclk1, sclk1, lrck1, dv1;
  logic [23:0] chl0, chr0, chl1, chr1;

  adc_controller #(.DATA_W(24), .BITS_PER_CH(32), .SCLK_HALF(2)) dut0 (
    .clk(clk), .rst(rst0), .sdata_adc(sd0),
    .mclk_adc(mclk0), .sclk_adc(sclk0), .lrck_adc(lrck0),
    .data_adc_chL(chl0), .data_adc_chR(chr0), .data_valid(dv0)
  );

  adc_controller #(.DATA_W(24), .BITS_PER_CH(25), .SCLK_HALF(1)) dut1 (
    .clk(clk), .rst(rst1), .sdata_adc(sd1),
    .mclk_adc(mclk1), .sclk_adc(sclk1), .lrck_adc(lrck1),
    .data_adc_chL(chl1), .data_adc_chR(chr1), .data_valid(dv1)
  );

  int checks = 0;
  int failures = 0;

  int e0 = 0;     // clk edges since reset release, instance 0
  int e1 = 0;     // same for instance 1
  int base0 = 0;  // pair-table index of frame 0 after the latest release
  int phase = 0;  // 0 = first run, 1 = after the mid-frame reset

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (e0=%0d e1=%0d)", name, act, exp, e0, e1);
    end
  endtask

  // Pair table for instance 0; index 3 is the frame interrupted by reset.
  function automatic logic [23:0] word_for(input bit inst1, input int idx, input bit right);
    logic [23:0] l, r;
    if (inst1) begin
      l = 24'h123456; r = 24'hFEDCBA;
    end else begin
      case (idx)
        0:       begin l = 24'hA5A5A5; r = 24'h5A5A5A; end
        1:       begin l = 24'h800001; r = 24'h7FFFFE; end
        2:       begin l = 24'hFFFFFF; r = 24'h000000; end
        3:       begin l = 24'h123456; r = 24'h654321; end
        4:       begin l = 24'h0F0F0F; r = 24'hF0F0F0; end
        default: begin l = 24'hC3C3C3; r = 24'h3C3C3C; end
      endcase
    end
    return right ? r : l;
  endfunction

  // ADC model: after e edges, e/(2*sh) falling edges have occurred, which is
  // the global slot number. Slot k of a channel carries bit dw-k; padding = 1.
  function automatic logic adc_bit(input int e, input int sh, input int bpc, input int dw,
                                   input bit inst1, input int base);
    int g, k, fr;
    bit ch;
    logic [23:0] w;
    g  = e / (2 * sh);
    k  = g % bpc;
    ch = ((g / bpc) % 2) == 1;
    fr = g / (2 * bpc);
    if (k >= 1 && k <= dw) begin
      w = word_for(inst1, base + fr, ch);
      return w[dw - k];
    end
    return 1'b1;
  endfunction

  // Compare all outputs against the closed-form expectation after e edges.
  task automatic check_inst(input bit inst1, input bit in_rst, input int e, input int sh,
                            input int bpc, input int dw, input int base,
                            input logic mclk, input logic sclk, input logic lrck,
                            input logic dv, input logic [23:0] cl, input logic [23:0] cr);
    int s0, per, m;
    logic em, es, el, ed;
    logic [23:0] xl, xr;
    string p;
    p = inst1 ? "i1" : "i0";
    em = 0; es = 0; el = 0; ed = 0; xl = 0; xr = 0;
    if (!in_rst) begin
      em = (e % 2) == 1;
      es = ((e / sh) % 2) == 1;
      el = ((e / (2 * sh * bpc)) % 2) == 1;
      s0  = (bpc + dw) * 2 * sh + sh + 1;
      per = 4 * sh * bpc;
      if (e >= s0) begin
        m  = (e - s0) / per;
        ed = ((e - s0) % per) == 0;
        xl = word_for(inst1, base + m, 1'b0);
        xr = word_for(inst1, base + m, 1'b1);
      end
    end
    chk({p, "_mclk"}, 32'(mclk), 32'(em));
    chk({p, "_sclk"}, 32'(sclk), 32'(es));
    chk({p, "_lrck"}, 32'(lrck), 32'(el));
    chk({p, "_valid"}, 32'(dv), 32'(ed));
    chk({p, "_chL"}, 32'(cl), 32'(xl));
    chk({p, "_chR"}, 32'(cr), 32'(xr));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst0) e0++;
    if (!rst1) e1++;
    check_inst(1'b0, rst0, e0, 2, 32, 24, base0, mclk0, sclk0, lrck0, dv0, chl0, chr0);
    check_inst(1'b1, rst1, e1, 1, 25, 24, 0, mclk1, sclk1, lrck1, dv1, chl1, chr1);

    // Hand-computed pins for instance 0.
    if (!rst0 && phase == 0) begin
      if (e0 == 1)   chk("pin_mclk_e1", 32'(mclk0), 32'd1);
      if (e0 == 2)   chk("pin_sclk_e2", 32'(sclk0), 32'd1);
      if (e0 == 127) chk("pin_lrck_e127", 32'(lrck0), 32'd0);
      if (e0 == 128) chk("pin_lrck_e128", 32'(lrck0), 32'd1);
      if (e0 == 226) chk("pin_valid_e226", 32'(dv0), 32'd0);
      if (e0 == 227) begin
        chk("pin_valid_e227", 32'(dv0), 32'd1);
        chk("pin_chL_e227", 32'(chl0), 32'hA5A5A5);
        chk("pin_chR_e227", 32'(chr0), 32'h5A5A5A);
      end
      if (e0 == 228) chk("pin_valid_e228", 32'(dv0), 32'd0);
      if (e0 == 483) begin
        chk("pin_chL_e483", 32'(chl0), 32'h800001);
        chk("pin_chR_e483", 32'(chr0), 32'h7FFFFE);
      end
      if (e0 == 739) begin
        chk("pin_chL_e739", 32'(chl0), 32'hFFFFFF);
        chk("pin_chR_e739", 32'(chr0), 32'h000000);
      end
    end
    if (!rst0 && phase == 1) begin
      if (e0 == 226) chk("pin_post_rst_chL_e226", 32'(chl0), 32'd0);
      if (e0 == 227) begin
        chk("pin_post_rst_valid", 32'(dv0), 32'd1);
        chk("pin_post_rst_chL", 32'(chl0), 32'h0F0F0F);
        chk("pin_post_rst_chR", 32'(chr0), 32'hF0F0F0);
      end
    end
    // Hand-computed pins for instance 1.
    if (!rst1) begin
      if (e1 == 1)  chk("pin_i1_sclk_e1", 32'(sclk1), 32'd1);
      if (e1 == 2)  chk("pin_i1_sclk_e2", 32'(sclk1), 32'd0);
      if (e1 == 99) chk("pin_i1_valid_e99", 32'(dv1), 32'd0);
      if (e1 == 100) begin
        chk("pin_i1_valid_e100", 32'(dv1), 32'd1);
        chk("pin_i1_chL_e100", 32'(chl1), 32'h123456);
        chk("pin_i1_chR_e100", 32'(chr1), 32'hFEDCBA);
      end
      if (e1 == 200) chk("pin_i1_valid_e200", 32'(dv1), 32'd1);
    end

    sd0 = rst0 ? 1'($urandom_range(0, 1)) : adc_bit(e0, 2, 32, 24, 1'b0, base0);
    sd1 = rst1 ? 1'($urandom_range(0, 1)) : adc_bit(e1, 1, 25, 24, 1'b1, 0);
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; sd0 = 1'b0; sd1 = 1'b0;
    #2;
    rst0 = 1'b1; rst1 = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Release both between edges so the next rising edge is edge 1.
    rst0 = 1'b0; rst1 = 1'b0;
    sd0 = adc_bit(0, 2, 32, 24, 1'b0, base0);
    sd1 = adc_bit(0, 1, 25, 24, 1'b1, 0);

    // Run into right slot 10 of the fourth frame (edge 3*256+128+42).
    while (e0 < 938) step();

    rst0 = 1'b1;
    #1;
    chk("mid_rst_chL", 32'(chl0), 32'd0);
    chk("mid_rst_chR", 32'(chr0), 32'd0);
    chk("mid_rst_valid", 32'(dv0), 32'd0);
    chk("mid_rst_lrck", 32'(lrck0), 32'd0);
    chk("mid_rst_sclk", 32'(sclk0), 32'd0);
    chk("mid_rst_mclk", 32'(mclk0), 32'd0);
    for (int i = 0; i < 5; i++) step();

    rst0 = 1'b0;
    e0 = 0;
    base0 = 4;
    phase = 1;
    sd0 = adc_bit(0, 2, 32, 24, 1'b0, base0);
    for (int i = 0; i < 300; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
